// File: rtl/inlet_seq_pkg.sv
// inlet_seq_pkg: shared state encoding and pump phase constants for the inlet dose sequencer
package inlet_seq_pkg;

    typedef enum logic [2:0] {IDLE, OPEN, PUMP, CLOSE, DONE} state_e;

    localparam logic [2:0] PH_IDLE = 3'b000;
    localparam logic [2:0] PH_A    = 3'b100;
    localparam logic [2:0] PH_B    = 3'b010;
    localparam logic [2:0] PH_C    = 3'b001;

endpackage

// File: rtl/seq_timer.sv
// seq_timer: loadable down-counter; expire is high while the count sits at zero
module seq_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q;

    // count down to zero and hold there until reloaded
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            cnt_q <= '0;
        else if (load_i)
            cnt_q <= load_val_i;
        else if (cnt_q != '0)
            cnt_q <= cnt_q - W'(1);

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/inlet_dose_sequencer.sv
// inlet_dose_sequencer: meters inlet fluid by sequencing the isolation valve and a three-phase pump
module inlet_dose_sequencer
    import inlet_seq_pkg::*;
#(
    parameter int CNT_W         = 8,
    parameter int PHASE_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CNT_W-1:0] req_strokes,
    input  logic             abort,
    output logic             valve_open,
    output logic [2:0]       pump_phase,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] strokes_done
);

    localparam int TMAX = (PHASE_CYCLES > SETTLE_CYCLES) ? PHASE_CYCLES : SETTLE_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    // a timer loaded with D-1 expires in the D-th cycle of a state
    localparam logic [TW-1:0] PH_LOAD = TW'(PHASE_CYCLES - 1);
    localparam logic [TW-1:0] ST_LOAD = TW'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [2:0]       phase_q, phase_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] strokes_q, strokes_d;
    logic [CNT_W-1:0] strokes_inc;
    logic             abort_q, abort_d;
    logic             valve_q, valve_d;
    logic [2:0]       pump_q, pump_d;
    logic             done_q, done_d;
    logic             tmr_load;
    logic [TW-1:0]    tmr_val;
    logic             tmr_exp;

    seq_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expire_o   (tmr_exp)
    );

    assign strokes_inc = strokes_q + CNT_W'(1);

    // next-state, timer control and next registered output values
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        target_d  = target_q;
        strokes_d = strokes_q;
        abort_d   = abort_q;
        tmr_load  = 1'b0;
        tmr_val   = PH_LOAD;
        case (state_q)
            IDLE: if (req_valid) begin
                target_d  = req_strokes;
                strokes_d = '0;
                abort_d   = 1'b0;
                tmr_load  = 1'b1;
                tmr_val   = ST_LOAD;
                state_d   = (req_strokes == '0) ? DONE : OPEN;
            end
            OPEN, PUMP: if (abort) begin
                abort_d  = 1'b1;
                state_d  = CLOSE;
                tmr_load = 1'b1;
                tmr_val  = ST_LOAD;
            end else if (tmr_exp) begin
                tmr_load = 1'b1;
                if (state_q == OPEN) begin
                    state_d = PUMP;
                    phase_d = PH_A;
                end else if (phase_q == PH_C) begin
                    strokes_d = strokes_inc;
                    phase_d   = PH_A;
                    if (strokes_inc == target_q) begin
                        state_d = CLOSE;
                        tmr_val = ST_LOAD;
                    end
                end else begin
                    phase_d = phase_q >> 1;
                end
            end
            CLOSE: if (tmr_exp) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        valve_d = (state_d == OPEN) || (state_d == PUMP);
        pump_d  = (state_d == PUMP) ? phase_d : PH_IDLE;
        done_d  = (state_d == DONE);
    end

    // state and registered output update; reset drops the valve immediately
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q   <= IDLE;
            phase_q   <= PH_IDLE;
            target_q  <= '0;
            strokes_q <= '0;
            abort_q   <= 1'b0;
            valve_q   <= 1'b0;
            pump_q    <= PH_IDLE;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            target_q  <= target_d;
            strokes_q <= strokes_d;
            abort_q   <= abort_d;
            valve_q   <= valve_d;
            pump_q    <= pump_d;
            done_q    <= done_d;
        end

    assign req_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign valve_open   = valve_q;
    assign pump_phase   = pump_q;
    assign done         = done_q;
    assign aborted      = abort_q;
    assign strokes_done = strokes_q;

endmodule

// File: tb/tb_inlet_dose_sequencer.sv
// tb_inlet_dose_sequencer: directed scenario checks for the inlet dose sequencer
module tb_inlet_dose_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_strokes = '0;
    logic       abort = 1'b0;
    logic       valve_open;
    logic [2:0] pump_phase;
    logic       busy, done, aborted;
    logic [7:0] strokes_done;

    logic       m_valid = 1'b0;
    logic       m_ready;
    logic [2:0] m_strokes = '0;
    logic       m_abort = 1'b0;
    logic       m_valve;
    logic [2:0] m_phase;
    logic       m_busy, m_done, m_aborted;
    logic [2:0] m_sd;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    inlet_dose_sequencer u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_strokes(req_strokes), .abort(abort), .valve_open(valve_open),
        .pump_phase(pump_phase), .busy(busy), .done(done), .aborted(aborted),
        .strokes_done(strokes_done)
    );

    inlet_dose_sequencer #(.CNT_W(3), .PHASE_CYCLES(1), .SETTLE_CYCLES(1)) u_max (
        .clk(clk), .rst_n(rst_n), .req_valid(m_valid), .req_ready(m_ready),
        .req_strokes(m_strokes), .abort(m_abort), .valve_open(m_valve),
        .pump_phase(m_phase), .busy(m_busy), .done(m_done), .aborted(m_aborted),
        .strokes_done(m_sd)
    );

    // present one request; the accepting edge is edge 0, next negedge samples cycle 1
    task automatic issue(input logic [7:0] n);
        @(negedge clk);
        req_valid = 1'b1;
        req_strokes = n;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        total++; if ({valve_open, pump_phase, busy, done, aborted} !== 7'b0) begin bad++; $display("FAIL reset_outputs got=%b want=0000000", {valve_open, pump_phase, busy, done, aborted}); end
        total++; if (strokes_done !== 8'd0) begin bad++; $display("FAIL reset_strokes got=%0d want=0", strokes_done); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_default;
        int rise = -1, fall = -1, dc = -1, perr = 0, k;
        logic ab = 1'bx, b1 = 1'bx, idle_ok = 1'b0;
        logic [7:0] sd = 'x;
        logic [2:0] exp_ph;
        issue(8'd2);
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c == 1) b1 = busy;
            if (valve_open && rise < 0) rise = c;
            if (!valve_open && rise >= 0 && fall < 0) fall = c;
            k = ((c - 9) / 4) % 3;
            exp_ph = (c < 9 || c > 32) ? 3'b000 : (k == 0) ? 3'b100 : (k == 1) ? 3'b010 : 3'b001;
            if (pump_phase !== exp_ph) perr++;
            if (dc > 0 && c == dc + 1) begin
                idle_ok = !done && !busy && req_ready;
                break;
            end
            if (done && dc < 0) begin dc = c; ab = aborted; sd = strokes_done; end
        end
        total++; if (rise !== 1) begin bad++; $display("FAIL default_valve_rise got=%0d want=1", rise); end
        total++; if (b1 !== 1'b1) begin bad++; $display("FAIL default_busy got=%b want=1", b1); end
        total++; if (perr !== 0) begin bad++; $display("FAIL default_phase_seq got=%0d_errs want=0", perr); end
        total++; if (fall !== 33) begin bad++; $display("FAIL default_valve_fall got=%0d want=33", fall); end
        total++; if (dc !== 41) begin bad++; $display("FAIL default_done_cycle got=%0d want=41", dc); end
        total++; if (ab !== 1'b0) begin bad++; $display("FAIL default_aborted got=%b want=0", ab); end
        total++; if (sd !== 8'd2) begin bad++; $display("FAIL default_strokes got=%0d want=2", sd); end
        total++; if (idle_ok !== 1'b1) begin bad++; $display("FAIL default_done_one_cycle got=%b want=1", idle_ok); end
    endtask

    task automatic test_zero;
        int act = 0;
        logic d1 = 1'bx;
        logic [7:0] sd = 'x;
        issue(8'd0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) begin d1 = done; sd = strokes_done; end
            if (valve_open || pump_phase != 3'b000) act++;
        end
        total++; if (d1 !== 1'b1) begin bad++; $display("FAIL zero_done_cycle1 got=%b want=1", d1); end
        total++; if (sd !== 8'd0) begin bad++; $display("FAIL zero_strokes got=%0d want=0", sd); end
        total++; if (act !== 0) begin bad++; $display("FAIL zero_actuators got=%0d want=0", act); end
    endtask

    task automatic test_abort;
        int dc = -1;
        logic [2:0] pre_ph = 'x, post_ph = 'x;
        logic post_valve = 1'bx, ab = 1'bx;
        logic [7:0] sd = 'x;
        issue(8'd5);
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c == 38) begin pre_ph = pump_phase; abort = 1'b1; end
            if (c == 39) begin post_ph = pump_phase; post_valve = valve_open; abort = 1'b0; end
            if (done) begin dc = c; ab = aborted; sd = strokes_done; break; end
        end
        abort = 1'b0;
        total++; if (pre_ph !== 3'b010) begin bad++; $display("FAIL abort_pre_phase got=%b want=010", pre_ph); end
        total++; if ({post_valve, post_ph} !== 4'b0000) begin bad++; $display("FAIL abort_close got=%b want=0000", {post_valve, post_ph}); end
        total++; if (dc !== 47) begin bad++; $display("FAIL abort_done_cycle got=%0d want=47", dc); end
        total++; if (ab !== 1'b1) begin bad++; $display("FAIL abort_flag got=%b want=1", ab); end
        total++; if (sd !== 8'd2) begin bad++; $display("FAIL abort_strokes got=%0d want=2", sd); end
    endtask

    task automatic test_back_to_back;
        int d1 = -1, d2 = -1, rdy_err = 0;
        logic rdy30 = 1'bx, open31 = 1'bx;
        logic [7:0] sd = 'x;
        @(negedge clk);
        req_valid = 1'b1;
        req_strokes = 8'd1;
        @(posedge clk);
        for (int c = 1; c <= 120; c++) begin
            @(negedge clk);
            if (c <= 29 && req_ready) rdy_err++;
            if (c == 30) rdy30 = req_ready;
            if (c == 31) begin open31 = busy && valve_open; req_valid = 1'b0; end
            if (done && d1 < 0) begin d1 = c; req_strokes = 8'd3; end
            else if (done && d1 > 0) begin d2 = c; sd = strokes_done; break; end
        end
        req_valid = 1'b0;
        total++; if (d1 !== 29) begin bad++; $display("FAIL b2b_first_done got=%0d want=29", d1); end
        total++; if (rdy_err !== 0) begin bad++; $display("FAIL b2b_ready_low got=%0d_errs want=0", rdy_err); end
        total++; if (rdy30 !== 1'b1) begin bad++; $display("FAIL b2b_idle_ready got=%b want=1", rdy30); end
        total++; if (open31 !== 1'b1) begin bad++; $display("FAIL b2b_second_accept got=%b want=1", open31); end
        total++; if (d2 !== 83) begin bad++; $display("FAIL b2b_second_done got=%0d want=83", d2); end
        total++; if (sd !== 8'd3) begin bad++; $display("FAIL b2b_strokes got=%0d want=3", sd); end
    endtask

    task automatic test_reset_mid;
        int dc = -1;
        logic [7:0] sd = 'x;
        issue(8'd2);
        repeat (25) @(negedge clk);
        total++; if ({valve_open, strokes_done} !== {1'b1, 8'd1}) begin bad++; $display("FAIL rmid_pre got=%b/%0d want=1/1", valve_open, strokes_done); end
        #2 rst_n = 1'b0;
        #1;
        total++; if ({valve_open, pump_phase, busy, done, aborted} !== 7'b0) begin bad++; $display("FAIL rmid_async_outputs got=%b want=0000000", {valve_open, pump_phase, busy, done, aborted}); end
        total++; if ({req_ready, strokes_done} !== {1'b1, 8'd0}) begin bad++; $display("FAIL rmid_async_ready_strokes got=%b/%0d want=1/0", req_ready, strokes_done); end
        @(negedge clk);
        rst_n = 1'b1;
        issue(8'd1);
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (done) begin dc = c; sd = strokes_done; break; end
        end
        total++; if (dc !== 29) begin bad++; $display("FAIL rmid_fresh_done got=%0d want=29", dc); end
        total++; if (sd !== 8'd1) begin bad++; $display("FAIL rmid_fresh_strokes got=%0d want=1", sd); end
    endtask

    task automatic test_max_count;
        int pc = 0, dc = -1, wrap = 0;
        logic [2:0] prev = '0;
        logic [2:0] sd = 'x;
        @(negedge clk);
        m_valid = 1'b1;
        m_strokes = 3'd7;
        @(posedge clk);
        #1 m_valid = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (m_phase != 3'b000) pc++;
            if (m_sd < prev) wrap++;
            prev = m_sd;
            if (m_done) begin dc = c; sd = m_sd; break; end
        end
        total++; if (pc !== 21) begin bad++; $display("FAIL max_pump_cycles got=%0d want=21", pc); end
        total++; if (dc !== 24) begin bad++; $display("FAIL max_done_cycle got=%0d want=24", dc); end
        total++; if (sd !== 3'd7) begin bad++; $display("FAIL max_strokes got=%0d want=7", sd); end
        total++; if (wrap !== 0) begin bad++; $display("FAIL max_no_wrap got=%0d want=0", wrap); end
    endtask

    initial begin
        test_reset;
        test_default;
        test_zero;
        test_abort;
        test_back_to_back;
        test_reset_mid;
        test_max_count;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inlet_dose_sequencer.md
# inlet_dose_sequencer

Clocked controller that meters fluid into a planar chip's primary inlet (the `Source1` port feeding the first Mixer) by sequencing the inlet isolation valve and a three-phase peristaltic pump. It accepts a dose request (a stroke count) over a valid/ready handshake. It then:

- opens the valve and waits for it to settle,
- runs the requested number of pump strokes,
- closes the valve and waits for it to settle,
- reports completion.

It sits directly upstream of the Mixer→Filter→Heater chain and is the only block that drives the chip's inlet actuators.

## Interface

Parameters:

- `CNT_W`, default 8: width of stroke count fields.
- `PHASE_CYCLES`, default 4: clock cycles each pump phase is held; must be ≥1.
- `SETTLE_CYCLES`, default 8: valve open and close settle time in cycles; must be ≥1.

Ports:

- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  a dose request is present.
- `req_ready`  out  1  sequencer can accept a request.
- `req_strokes`  in  CNT_W  number of pump strokes requested.
- `abort`  in  1  level; terminates an active dose early.
- `valve_open`  out  1  inlet isolation valve drive.
- `pump_phase`  out  3  one-hot peristaltic phase drive; 000 means pump idle.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `aborted`  out  1  registered with `done`; high if the dose ended via `abort`.
- `strokes_done`  out  CNT_W  strokes completed in the current or most recent dose.

## Operation

- **States:** IDLE, OPEN, PUMP, CLOSE, DONE.
- **IDLE:**
  - `req_ready=1`.
  - A handshake (`req_valid && req_ready`) latches `req_strokes` and clears `strokes_done` to 0.
  - If the latched count is 0, go to DONE. No valve or pump activity occurs.
  - Otherwise go to OPEN.
- **OPEN:**
  - `valve_open=1`, `pump_phase=000`.
  - Stay SETTLE_CYCLES cycles, then go to PUMP.
- **PUMP:**
  - `valve_open=1`.
  - `pump_phase` steps 100→010→001, each phase held PHASE_CYCLES cycles. One stroke is three phases.
  - At the end of phase 001, `strokes_done` increments.
  - When `strokes_done` reaches the target, go to CLOSE. Otherwise restart at phase 100.
- **CLOSE:**
  - `valve_open=0`, `pump_phase=000`.
  - Stay SETTLE_CYCLES cycles, then go to DONE.
- **DONE:**
  - `done=1` for exactly one cycle, then go to IDLE.
  - `aborted` equals the latched abort flag.
- **Abort:**
  - `abort` sampled high in OPEN or PUMP sets the abort flag and forces CLOSE on the next cycle.
  - A partial stroke does not increment `strokes_done`.
  - `abort` is ignored in IDLE, CLOSE and DONE.
  - The abort flag is cleared on the next accepted request.
- **Counter width:** a count of 2^CNT_W−1 must complete without wrap. The stroke counter and the target are both CNT_W wide; comparison is equality.
- **No queuing:** `req_ready=0` outside IDLE. A request held valid during a dose is accepted in the first IDLE cycle after DONE.

## Timing

- **Reset values:** reset asserted drives, asynchronously:
  - state=IDLE
  - `valve_open=0`, `pump_phase=000`
  - `busy=0`, `done=0`, `aborted=0`
  - `strokes_done=0`
  - `req_ready=1`
- **Reset mid-dose:** the valve closes immediately, without a settle period.
- **Registered outputs:** all outputs are registered; `req_ready` and `busy` decode state.
- **Latency:** a request accepted at edge 0 yields OPEN from cycle 1. `done` is high in cycle 2·S + 3·P·N + 1, where S=SETTLE_CYCLES, P=PHASE_CYCLES and N=strokes.
- **Zero strokes:** `done` is high in cycle 1.
- **Abort timing:** abort sampled at edge k in OPEN or PUMP gives CLOSE in cycle k+1 and `done` in cycle k+S+1.
- **Back-to-back requests:** minimum spacing between accepts is latency + 1 (the DONE→IDLE cycle).

## Structure

- **Package `inlet_seq_pkg`:**
  - state enum (IDLE, OPEN, PUMP, CLOSE, DONE)
  - phase constants (PH_IDLE=3'b000, PH_A=3'b100, PH_B=3'b010, PH_C=3'b001)
- **Sub-module `seq_timer`:**
  - loadable down-counter with `load`, `load_val` and a `expire` pulse.
  - Width is `$clog2(max(PHASE_CYCLES,SETTLE_CYCLES)+1)`.
  - One instance is shared by the settle and phase timing.

## Test plan

- **Default dose:** defaults, request `req_strokes=2`.
  - valve rises in cycle 1.
  - phase sequence 100,010,001 ×2, each held 4 cycles, in cycles 9–32.
  - valve falls in cycle 33.
  - `done=1` in cycle 41, `aborted=0`, `strokes_done=2`.
- **Zero strokes:** `req_strokes=0`.
  - `done` in cycle 1.
  - `valve_open` and `pump_phase` never leave 0.
  - `strokes_done=0`.
- **Abort mid-stroke:** `req_strokes=5`, `abort` pulsed during the 2nd phase of stroke 3.
  - CLOSE next cycle; valve low, phase 000.
  - `done` S+1 cycles after the abort sample, with `aborted=1` and `strokes_done=2`.
- **Back-to-back requests:** `req_valid` held with `req_strokes=1`, then 3.
  - second accept exactly one cycle after the first `done`.
  - `req_ready=0` throughout the first dose.
- **Reset mid-dose:** assert `rst_n=0` mid-PUMP.
  - outputs reach their reset values without waiting for a clock.
  - after release, a fresh `req_strokes=1` dose completes in cycle 2S+3P+1=29.
- **Maximum count:** `CNT_W=3`, `PHASE_CYCLES=1`, `SETTLE_CYCLES=1`, `req_strokes=7`.
  - 21 PUMP cycles, `strokes_done=7`, no wrap.
  - `done` in cycle 24.
